// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: serialises operand fetches and writebacks onto the single bank port, with r0 forced to zero and bounded fetch starvation; define REGFILE_SAME_SRC_SKIP_EN to skip READ_B when rs == rt.
module regfile_access_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req_valid,
  output logic        rd_req_ready,
  input  logic [4:0]  rd_rs,
  input  logic [4:0]  rd_rt,
  output logic        rd_rsp_valid,
  output logic [31:0] rd_rsp_a,
  output logic [31:0] rd_rsp_b,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [4:0]  bank_addr,
  output logic        bank_we,
  output logic [31:0] bank_wdata,
  input  logic [31:0] bank_rdata
);
  typedef enum logic [1:0] {IDLE, READ_A, READ_B, WRITE} state_t;
  state_t state, state_nx;
  logic [4:0] rs_q, rt_q, rd_q;
  logic [31:0] wd_q;
  logic [1:0] cnt;
  logic sat, rd_go, wb_go, same;
`ifdef REGFILE_SAME_SRC_SKIP_EN
  assign same = rs_q == rt_q;
`else
  assign same = 1'b0;
`endif
  // handshake arbitration, next state and bank port drive
  always_comb begin
    sat = cnt == 2'd3;
    rd_req_ready = state == IDLE && (!wb_valid || sat);
    wb_ready = state == IDLE && !(sat && rd_req_valid);
    rd_go = rd_req_valid && rd_req_ready;
    wb_go = wb_valid && wb_ready && !rd_go;
    state_nx = state == IDLE ? (rd_go ? READ_A : wb_go ? WRITE : IDLE) :
               state == READ_A ? (same ? IDLE : READ_B) : IDLE;
    bank_addr = state == READ_A ? rs_q : state == READ_B ? rt_q : state == WRITE ? rd_q : 5'd0;
    bank_we = state == WRITE && rd_q != 5'd0;
    bank_wdata = state == WRITE ? wd_q : 32'd0;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // request latches, starvation counter and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
      wd_q <= '0;
      cnt <= '0;
      rd_rsp_valid <= 1'b0;
      rd_rsp_a <= '0;
      rd_rsp_b <= '0;
    end else begin
      if (rd_go) begin
        rs_q <= rd_rs;
        rt_q <= rd_rt;
      end
      if (wb_go) begin
        rd_q <= wb_rd;
        wd_q <= wb_data;
      end
      cnt <= rd_go ? 2'd0 : (wb_go && rd_req_valid) ? cnt + 2'd1 : cnt;
      rd_rsp_valid <= state == READ_B || (state == READ_A && same);
      if (state == READ_A) begin
        rd_rsp_a <= rs_q == 5'd0 ? 32'd0 : bank_rdata;
        if (same) rd_rsp_b <= rs_q == 5'd0 ? 32'd0 : bank_rdata;
      end
      if (state == READ_B) rd_rsp_b <= rt_q == 5'd0 ? 32'd0 : bank_rdata;
    end
  end
endmodule
